// File: rtl/axi_slave_reg_connector.sv
// axi_slave_reg_connector
// Converts a flat slave-side AXI port bundle into an axi_conf::req_t /
// axi_conf::resp_t pair. Every channel (AW, W, AR forward; B, R backward)
// passes through its own two-entry skid buffer, so valid, ready and payload
// are all registered at both boundaries.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   s_axi_aw* / s_axi_ar*   address channels from the external master
//   s_axi_w*                write data channel from the external master
//   s_axi_b* / s_axi_r*     response channels toward the external master
//   axi_req_o               AW/W/AR payload+valid, b_ready, r_ready to fabric
//   axi_resp_i              aw/w/ar ready, B/R payload+valid from fabric

package axi_conf;
  localparam int unsigned IdW   = 8;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned StrbW = DataW / 8;
  localparam int unsigned UserW = 1;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic             lock;
    logic [3:0]       cache;
    logic [2:0]       prot;
    logic [3:0]       qos;
    logic [3:0]       region;
    logic [5:0]       atop;
    logic [UserW-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic             lock;
    logic [3:0]       cache;
    logic [2:0]       prot;
    logic [3:0]       qos;
    logic [3:0]       region;
    logic [UserW-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [StrbW-1:0] strb;
    logic             last;
    logic [UserW-1:0] user;
  } w_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [1:0]       resp;
    logic [UserW-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
    logic [UserW-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } resp_t;
endpackage

// Two-entry skid buffer: main register drives the output, skid register
// absorbs the one beat that can arrive while the output stalls.
module axi_slave_reg_connector_skid #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data
);
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_acc;
  logic             w_pop;
  logic             w_main_from_in;
  logic             w_main_from_skid;
  logic             w_skid_from_in;

  assign o_out_valid = (r_state != S_EMPTY);
  assign o_out_data  = r_main;
  assign o_in_ready  = r_in_ready;
  assign w_acc       = i_in_valid & r_in_ready;
  assign w_pop       = o_out_valid & i_out_ready;

  // State register; ready is registered from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != S_FULL);
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: if (w_acc) w_state_next = S_ONE;
      S_ONE: begin
        if (w_acc && !w_pop)      w_state_next = S_FULL;
        else if (!w_acc && w_pop) w_state_next = S_EMPTY;
      end
      S_FULL:  if (w_pop) w_state_next = S_ONE;
      default: w_state_next = S_EMPTY;
    endcase
  end

  // Datapath load enables.
  always_comb begin
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    case (r_state)
      S_EMPTY: w_main_from_in = w_acc;
      S_ONE: begin
        w_main_from_in = w_acc & w_pop;
        w_skid_from_in = w_acc & ~w_pop;
      end
      S_FULL:  w_main_from_skid = w_pop;
      default: ;
    endcase
  end

  // Payload registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_main_from_in)        r_main <= i_in_data;
      else if (w_main_from_skid) r_main <= r_skid;
      if (w_skid_from_in)        r_skid <= i_in_data;
    end
  end
endmodule

module axi_slave_reg_connector #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH     = 8,
  parameter int unsigned AWUSER_WIDTH = 1,
  parameter int unsigned WUSER_WIDTH  = 1,
  parameter int unsigned BUSER_WIDTH  = 1,
  parameter int unsigned ARUSER_WIDTH = 1,
  parameter int unsigned RUSER_WIDTH  = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic [3:0]              s_axi_awregion,
  input  logic [AWUSER_WIDTH-1:0] s_axi_awuser,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]   s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic [WUSER_WIDTH-1:0]  s_axi_wuser,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic [BUSER_WIDTH-1:0]  s_axi_buser,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic [RUSER_WIDTH-1:0]  s_axi_ruser,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output axi_conf::req_t          axi_req_o,
  input  axi_conf::resp_t         axi_resp_i
);
  localparam int unsigned PkgIdW   = axi_conf::IdW;
  localparam int unsigned PkgAddrW = axi_conf::AddrW;
  localparam int unsigned PkgDataW = axi_conf::DataW;
  localparam int unsigned PkgStrbW = axi_conf::StrbW;
  localparam int unsigned PkgUserW = axi_conf::UserW;
  localparam int unsigned AwW      = $bits(axi_conf::aw_chan_t);
  localparam int unsigned WW       = $bits(axi_conf::w_chan_t);
  localparam int unsigned ArW      = $bits(axi_conf::ar_chan_t);
  localparam int unsigned BW       = $bits(axi_conf::b_chan_t);
  localparam int unsigned RW       = $bits(axi_conf::r_chan_t);

  axi_conf::aw_chan_t w_aw_in, w_aw_out;
  axi_conf::w_chan_t  w_w_in,  w_w_out;
  axi_conf::ar_chan_t w_ar_in, w_ar_out;
  axi_conf::b_chan_t  w_b_out;
  axi_conf::r_chan_t  w_r_out;
  logic w_aw_valid, w_w_valid, w_ar_valid, w_b_ready, w_r_ready;

  // Pack the flat master-side fields into fabric channel structs; atop is 0.
  always_comb begin
    w_aw_in        = '0;
    w_aw_in.id     = PkgIdW'(s_axi_awid);
    w_aw_in.addr   = PkgAddrW'(s_axi_awaddr);
    w_aw_in.len    = s_axi_awlen;
    w_aw_in.size   = s_axi_awsize;
    w_aw_in.burst  = s_axi_awburst;
    w_aw_in.lock   = s_axi_awlock;
    w_aw_in.cache  = s_axi_awcache;
    w_aw_in.prot   = s_axi_awprot;
    w_aw_in.qos    = s_axi_awqos;
    w_aw_in.region = s_axi_awregion;
    w_aw_in.user   = PkgUserW'(s_axi_awuser);

    w_w_in         = '0;
    w_w_in.data    = PkgDataW'(s_axi_wdata);
    w_w_in.strb    = PkgStrbW'(s_axi_wstrb);
    w_w_in.last    = s_axi_wlast;
    w_w_in.user    = PkgUserW'(s_axi_wuser);

    w_ar_in        = '0;
    w_ar_in.id     = PkgIdW'(s_axi_arid);
    w_ar_in.addr   = PkgAddrW'(s_axi_araddr);
    w_ar_in.len    = s_axi_arlen;
    w_ar_in.size   = s_axi_arsize;
    w_ar_in.burst  = s_axi_arburst;
    w_ar_in.lock   = s_axi_arlock;
    w_ar_in.cache  = s_axi_arcache;
    w_ar_in.prot   = s_axi_arprot;
    w_ar_in.qos    = s_axi_arqos;
    w_ar_in.region = s_axi_arregion;
    w_ar_in.user   = PkgUserW'(s_axi_aruser);
  end

  axi_slave_reg_connector_skid #(.WIDTH(AwW)) u_aw_skid (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_in_valid(s_axi_awvalid), .o_in_ready(s_axi_awready), .i_in_data(w_aw_in),
    .o_out_valid(w_aw_valid), .i_out_ready(axi_resp_i.aw_ready), .o_out_data(w_aw_out)
  );

  axi_slave_reg_connector_skid #(.WIDTH(WW)) u_w_skid (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_in_valid(s_axi_wvalid), .o_in_ready(s_axi_wready), .i_in_data(w_w_in),
    .o_out_valid(w_w_valid), .i_out_ready(axi_resp_i.w_ready), .o_out_data(w_w_out)
  );

  axi_slave_reg_connector_skid #(.WIDTH(ArW)) u_ar_skid (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_in_valid(s_axi_arvalid), .o_in_ready(s_axi_arready), .i_in_data(w_ar_in),
    .o_out_valid(w_ar_valid), .i_out_ready(axi_resp_i.ar_ready), .o_out_data(w_ar_out)
  );

  axi_slave_reg_connector_skid #(.WIDTH(BW)) u_b_skid (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_in_valid(axi_resp_i.b_valid), .o_in_ready(w_b_ready), .i_in_data(axi_resp_i.b),
    .o_out_valid(s_axi_bvalid), .i_out_ready(s_axi_bready), .o_out_data(w_b_out)
  );

  axi_slave_reg_connector_skid #(.WIDTH(RW)) u_r_skid (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_in_valid(axi_resp_i.r_valid), .o_in_ready(w_r_ready), .i_in_data(axi_resp_i.r),
    .o_out_valid(s_axi_rvalid), .i_out_ready(s_axi_rready), .o_out_data(w_r_out)
  );

  // Fabric-side request assembled in one place.
  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw       = w_aw_out;
    axi_req_o.aw_valid = w_aw_valid;
    axi_req_o.w        = w_w_out;
    axi_req_o.w_valid  = w_w_valid;
    axi_req_o.ar       = w_ar_out;
    axi_req_o.ar_valid = w_ar_valid;
    axi_req_o.b_ready  = w_b_ready;
    axi_req_o.r_ready  = w_r_ready;
  end

  assign s_axi_bid   = ID_WIDTH'(w_b_out.id);
  assign s_axi_bresp = w_b_out.resp;
  assign s_axi_buser = BUSER_WIDTH'(w_b_out.user);
  assign s_axi_rid   = ID_WIDTH'(w_r_out.id);
  assign s_axi_rdata = DATA_WIDTH'(w_r_out.data);
  assign s_axi_rresp = w_r_out.resp;
  assign s_axi_rlast = w_r_out.last;
  assign s_axi_ruser = RUSER_WIDTH'(w_r_out.user);
endmodule

// File: tb/tb_axi_slave_reg_connector.sv
module tb_axi_slave_reg_connector;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  s_axi_awid;   logic [31:0] s_axi_awaddr; logic [7:0] s_axi_awlen;
  logic [2:0]  s_axi_awsize; logic [1:0]  s_axi_awburst; logic s_axi_awlock;
  logic [3:0]  s_axi_awcache; logic [2:0] s_axi_awprot; logic [3:0] s_axi_awqos;
  logic [3:0]  s_axi_awregion; logic [0:0] s_axi_awuser; logic s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata; logic [3:0] s_axi_wstrb; logic s_axi_wlast; logic [0:0] s_axi_wuser;
  logic        s_axi_wvalid, s_axi_wready;
  logic [7:0]  s_axi_bid; logic [1:0] s_axi_bresp; logic [0:0] s_axi_buser;
  logic        s_axi_bvalid, s_axi_bready;
  logic [7:0]  s_axi_arid;   logic [31:0] s_axi_araddr; logic [7:0] s_axi_arlen;
  logic [2:0]  s_axi_arsize; logic [1:0]  s_axi_arburst; logic s_axi_arlock;
  logic [3:0]  s_axi_arcache; logic [2:0] s_axi_arprot; logic [3:0] s_axi_arqos;
  logic [3:0]  s_axi_arregion; logic [0:0] s_axi_aruser; logic s_axi_arvalid, s_axi_arready;
  logic [7:0]  s_axi_rid; logic [31:0] s_axi_rdata; logic [1:0] s_axi_rresp; logic s_axi_rlast;
  logic [0:0]  s_axi_ruser; logic s_axi_rvalid, s_axi_rready;
  axi_conf::req_t  axi_req;
  axi_conf::resp_t axi_resp;

  axi_slave_reg_connector dut (
    .clk_i(clk), .rst_i(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
    .s_axi_awregion(s_axi_awregion), .s_axi_awuser(s_axi_awuser),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wuser(s_axi_wuser), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_buser(s_axi_buser),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
    .s_axi_arregion(s_axi_arregion), .s_axi_aruser(s_axi_aruser),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_ruser(s_axi_ruser),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .axi_req_o(axi_req), .axi_resp_i(axi_resp)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: one queue per channel (0 AW, 1 W, 2 AR, 3 B, 4 R).
  logic [127:0] q_aw[$], q_w[$], q_ar[$], q_b[$], q_r[$];
  logic         in_v[5], in_r[5], out_v[5], out_r[5];
  logic [127:0] in_pl[5], out_pl[5];
  logic         prev_stall[5];
  logic [127:0] prev_pl[5];

  function automatic void sb_push(input int c, input logic [127:0] v);
    case (c)
      0: q_aw.push_back(v);
      1: q_w.push_back(v);
      2: q_ar.push_back(v);
      3: q_b.push_back(v);
      default: q_r.push_back(v);
    endcase
  endfunction

  function automatic int sb_size(input int c);
    case (c)
      0: return q_aw.size();
      1: return q_w.size();
      2: return q_ar.size();
      3: return q_b.size();
      default: return q_r.size();
    endcase
  endfunction

  function automatic logic [127:0] sb_pop(input int c);
    case (c)
      0: return q_aw.pop_front();
      1: return q_w.pop_front();
      2: return q_ar.pop_front();
      3: return q_b.pop_front();
      default: return q_r.pop_front();
    endcase
  endfunction

  function automatic void sb_clear();
    q_aw.delete(); q_w.delete(); q_ar.delete(); q_b.delete(); q_r.delete();
    for (int c = 0; c < 5; c++) prev_stall[c] = 1'b0;
  endfunction

  // Expected fabric-side payloads built from the stimulus (atop always 0).
  function automatic void sample();
    axi_conf::aw_chan_t aw;
    axi_conf::w_chan_t  w;
    axi_conf::ar_chan_t ar;
    aw = '0;
    aw.id = s_axi_awid; aw.addr = s_axi_awaddr; aw.len = s_axi_awlen; aw.size = s_axi_awsize;
    aw.burst = s_axi_awburst; aw.lock = s_axi_awlock; aw.cache = s_axi_awcache;
    aw.prot = s_axi_awprot; aw.qos = s_axi_awqos; aw.region = s_axi_awregion; aw.user = s_axi_awuser;
    w.data = s_axi_wdata; w.strb = s_axi_wstrb; w.last = s_axi_wlast; w.user = s_axi_wuser;
    ar.id = s_axi_arid; ar.addr = s_axi_araddr; ar.len = s_axi_arlen; ar.size = s_axi_arsize;
    ar.burst = s_axi_arburst; ar.lock = s_axi_arlock; ar.cache = s_axi_arcache;
    ar.prot = s_axi_arprot; ar.qos = s_axi_arqos; ar.region = s_axi_arregion; ar.user = s_axi_aruser;
    in_v[0] = s_axi_awvalid; in_r[0] = s_axi_awready; in_pl[0] = 128'(aw);
    out_v[0] = axi_req.aw_valid; out_r[0] = axi_resp.aw_ready; out_pl[0] = 128'(axi_req.aw);
    in_v[1] = s_axi_wvalid; in_r[1] = s_axi_wready; in_pl[1] = 128'(w);
    out_v[1] = axi_req.w_valid; out_r[1] = axi_resp.w_ready; out_pl[1] = 128'(axi_req.w);
    in_v[2] = s_axi_arvalid; in_r[2] = s_axi_arready; in_pl[2] = 128'(ar);
    out_v[2] = axi_req.ar_valid; out_r[2] = axi_resp.ar_ready; out_pl[2] = 128'(axi_req.ar);
    in_v[3] = axi_resp.b_valid; in_r[3] = axi_req.b_ready;
    in_pl[3] = 128'({axi_resp.b.id, axi_resp.b.resp, axi_resp.b.user});
    out_v[3] = s_axi_bvalid; out_r[3] = s_axi_bready;
    out_pl[3] = 128'({s_axi_bid, s_axi_bresp, s_axi_buser});
    in_v[4] = axi_resp.r_valid; in_r[4] = axi_req.r_ready;
    in_pl[4] = 128'({axi_resp.r.id, axi_resp.r.data, axi_resp.r.resp, axi_resp.r.last, axi_resp.r.user});
    out_v[4] = s_axi_rvalid; out_r[4] = s_axi_rready;
    out_pl[4] = 128'({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser});
  endfunction

  // Book the handshakes that the next rising edge will perform, then advance.
  task automatic cycle();
    sample();
    if (rst) begin
      sb_clear();
    end else begin
      for (int c = 0; c < 5; c++) begin
        if (prev_stall[c]) begin
          check($sformatf("hold_valid_ch%0d", c), 128'(out_v[c]), 128'(1));
          check($sformatf("hold_data_ch%0d", c), out_pl[c], prev_pl[c]);
        end
        if (in_v[c] && in_r[c]) sb_push(c, in_pl[c]);
        if (out_v[c] && out_r[c]) begin
          if (sb_size(c) == 0) begin
            n_checks++; n_errors++;
            $display("FAIL extra_beat_ch%0d: got %0h expected none", c, out_pl[c]);
          end else begin
            check($sformatf("order_ch%0d", c), out_pl[c], sb_pop(c));
          end
        end
        prev_stall[c] = out_v[c] & ~out_r[c];
        prev_pl[c]    = out_pl[c];
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [4:0] valids();
    return {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid, s_axi_bvalid, s_axi_rvalid};
  endfunction

  function automatic logic [4:0] readies();
    return {s_axi_awready, s_axi_wready, s_axi_arready, axi_req.b_ready, axi_req.r_ready};
  endfunction

  task automatic idle_inputs();
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0; s_axi_awqos = '0;
    s_axi_awregion = '0; s_axi_awuser = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wuser = '0; s_axi_wvalid = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
    s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0; s_axi_arqos = '0;
    s_axi_arregion = '0; s_axi_aruser = '0; s_axi_arvalid = 1'b0;
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    axi_resp = '0;
  endtask

  task automatic rand_inputs();
    s_axi_awvalid = 1'($urandom); s_axi_awid = 8'($urandom); s_axi_awaddr = $urandom;
    s_axi_awlen = 8'($urandom); s_axi_awsize = 3'($urandom); s_axi_awburst = 2'($urandom);
    s_axi_awlock = 1'($urandom); s_axi_awcache = 4'($urandom); s_axi_awprot = 3'($urandom);
    s_axi_awqos = 4'($urandom); s_axi_awregion = 4'($urandom); s_axi_awuser = 1'($urandom);
    s_axi_wvalid = 1'($urandom); s_axi_wdata = $urandom; s_axi_wstrb = 4'($urandom);
    s_axi_wlast = 1'($urandom); s_axi_wuser = 1'($urandom);
    s_axi_arvalid = 1'($urandom); s_axi_arid = 8'($urandom); s_axi_araddr = $urandom;
    s_axi_arlen = 8'($urandom); s_axi_arsize = 3'($urandom); s_axi_arburst = 2'($urandom);
    s_axi_arlock = 1'($urandom); s_axi_arcache = 4'($urandom); s_axi_arprot = 3'($urandom);
    s_axi_arqos = 4'($urandom); s_axi_arregion = 4'($urandom); s_axi_aruser = 1'($urandom);
    s_axi_bready = 1'($urandom); s_axi_rready = 1'($urandom);
    axi_resp.aw_ready = 1'($urandom); axi_resp.w_ready = 1'($urandom);
    axi_resp.ar_ready = 1'($urandom);
    axi_resp.b_valid = 1'($urandom); axi_resp.b.id = 8'($urandom);
    axi_resp.b.resp = 2'($urandom); axi_resp.b.user = 1'($urandom);
    axi_resp.r_valid = 1'($urandom); axi_resp.r.id = 8'($urandom); axi_resp.r.data = $urandom;
    axi_resp.r.resp = 2'($urandom); axi_resp.r.last = 1'($urandom); axi_resp.r.user = 1'($urandom);
  endtask

  initial begin
    int idx;
    int pops;
    logic [31:0] got_addr[$];
    sb_clear();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);

    // Reset values
    cycle();
    cycle();
    check("rst_valids", 128'(valids()), 128'(0));
    check("rst_readies", 128'(readies()), 128'(0));
    check("rst_req_payload", 128'(|axi_req), 128'(0));
    check("rst_b_payload", 128'({s_axi_bid, s_axi_bresp, s_axi_buser}), 128'(0));
    check("rst_r_payload", 128'({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser}), 128'(0));
    rst = 1'b0;
    cycle();
    check("post_rst_readies", 128'(readies()), 128'(5'b11111));
    check("post_rst_valids", 128'(valids()), 128'(0));

    // Single AR beat, one-cycle latency
    axi_resp.ar_ready = 1'b1;
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h1000; s_axi_arid = 8'd3; s_axi_arlen = 8'd0;
    check("ar_ready_c0", 128'(s_axi_arready), 128'(1));
    cycle();
    s_axi_arvalid = 1'b0;
    check("ar_valid_c1", 128'(axi_req.ar_valid), 128'(1));
    check("ar_fields_c1", 128'({axi_req.ar.id, axi_req.ar.addr, axi_req.ar.len}),
          128'({8'd3, 32'h1000, 8'd0}));
    check("ar_ready_c1", 128'(s_axi_arready), 128'(1));
    cycle();
    check("ar_popped", 128'(axi_req.ar_valid), 128'(0));

    // Streaming W, 16 beats back-to-back
    axi_resp.w_ready = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      s_axi_wvalid = (k < 16);
      s_axi_wdata  = 32'(k);
      s_axi_wstrb  = 4'hf;
      s_axi_wlast  = (k == 15);
      if (k < 16) check("w_stream_ready", 128'(s_axi_wready), 128'(1));
      if (k >= 1) begin
        check("w_stream_valid", 128'(axi_req.w_valid), 128'(1));
        check("w_stream_beat", 128'({axi_req.w.last, axi_req.w.data}),
              128'({(k - 1) == 15, 32'(k - 1)}));
      end
      cycle();
    end
    idle_inputs();
    check("w_stream_done", 128'(axi_req.w_valid), 128'(0));

    // AW backpressure: only two beats fit while the fabric stalls
    idx = 0;
    for (int t = 0; t < 6; t++) begin
      logic acc;
      s_axi_awvalid = (idx < 3);
      s_axi_awaddr  = 32'(idx * 64);
      acc = s_axi_awvalid & s_axi_awready;
      cycle();
      if (acc) idx++;
    end
    check("aw_bp_accepted", 128'(idx), 128'(2));
    check("aw_bp_ready_low", 128'(s_axi_awready), 128'(0));
    axi_resp.aw_ready = 1'b1;
    got_addr.delete();
    for (int t = 0; t < 8; t++) begin
      logic acc;
      s_axi_awvalid = (idx < 3);
      s_axi_awaddr  = 32'(idx * 64);
      acc = s_axi_awvalid & s_axi_awready;
      if (axi_req.aw_valid) got_addr.push_back(axi_req.aw.addr);
      cycle();
      if (acc) idx++;
    end
    check("aw_bp_count", 128'(got_addr.size()), 128'(3));
    if (got_addr.size() == 3)
      check("aw_bp_addrs", 128'({got_addr[0], got_addr[1], got_addr[2]}),
            128'({32'h0, 32'h40, 32'h80}));
    idle_inputs();

    // R burst of 4 with toggling master ready
    idx = 0;
    pops = 0;
    for (int t = 0; t < 16; t++) begin
      logic acc;
      axi_resp.r_valid  = (idx < 4);
      axi_resp.r.id     = 8'd5;
      axi_resp.r.resp   = 2'd0;
      axi_resp.r.data   = 32'(32'hA0 + idx);
      axi_resp.r.last   = (idx == 3);
      s_axi_rready      = ((t % 2) == 0);
      acc = axi_resp.r_valid & axi_req.r_ready;
      if (s_axi_rvalid && s_axi_rready) begin
        check("r_beat", 128'({s_axi_rid, s_axi_rdata, s_axi_rlast}),
              128'({8'd5, 32'(32'hA0 + pops), pops == 3}));
        pops++;
      end
      cycle();
      if (acc) idx++;
    end
    check("r_count", 128'(pops), 128'(4));
    idle_inputs();

    // Reset with a full W buffer
    for (int k = 0; k < 2; k++) begin
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = 32'(32'h11 * (k + 1));
      cycle();
    end
    s_axi_wvalid = 1'b0;
    cycle();
    check("wfull_ready_low", 128'(s_axi_wready), 128'(0));
    check("wfull_valid", 128'(axi_req.w_valid), 128'(1));
    axi_resp.w_ready = 1'b1;
    rst = 1'b1;
    cycle();
    check("midrst_valids", 128'(valids()), 128'(0));
    check("midrst_readies", 128'(readies()), 128'(0));
    rst = 1'b0;
    cycle();
    check("midrst_readies_up", 128'(readies()), 128'(5'b11111));
    check("midrst_no_stale", 128'(valids()), 128'(0));
    cycle();
    check("midrst_no_stale2", 128'(axi_req.w_valid), 128'(0));

    // Random concurrency on all channels
    for (int t = 0; t < 4000; t++) begin
      rand_inputs();
      cycle();
    end
    idle_inputs();
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1; axi_resp.ar_ready = 1'b1;
    for (int t = 0; t < 8; t++) cycle();
    for (int c = 0; c < 5; c++)
      check($sformatf("drain_ch%0d", c), 128'(sb_size(c)), 128'(0));
    check("drain_valids", 128'(valids()), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
